// File: rtl/costas_mix_int_dump.sv
// Costas arm mixer with integrate-and-dump: ADC x NCO product, summed over DUMP_LEN valid
// samples, then shifted, saturated and strobed out. Optional rounding: COSTAS_DUMP_ROUND_EN.
module costas_mix_int_dump #(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned LO_W     = 14,
    parameter int unsigned DUMP_LEN = 1000,
    parameter int unsigned ACC_W    = 38,
    parameter int unsigned SHIFT    = 20,
    parameter int unsigned OUT_W    = 18
) (
    input  logic                            clock,
    input  logic                            resest,
    input  logic signed [DATA_W-1:0]        adc_data,
    input  logic                            adc_valid,
    input  logic signed [LO_W-1:0]          lo_sin,
    input  logic                            clear,
    output logic signed [DATA_W+LO_W-1:0]   mix_o,
    output logic                            mix_valid,
    output logic signed [OUT_W-1:0]         acc_o,
    output logic                            acc_valid,
    output logic                            sat_flag
);

    localparam int unsigned PROD_W = DATA_W + LO_W;
    localparam int unsigned CNT_W  = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_LEN - 1);

    // Clamp limits expressed at the widened (ACC_W+1) sum width.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

`ifdef COSTAS_DUMP_ROUND_EN
    localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND_ONE = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [ACC_W:0] RND = (SHIFT > 0) ? (RND_ONE << RND_POS) : '0;
`else
    localparam logic [ACC_W:0] RND = '0;
`endif

    logic signed [DATA_W-1:0] adc_q;
    logic signed [LO_W-1:0]   lo_q;
    logic                     v1_q;

    logic signed [PROD_W-1:0] adc_ext;
    logic signed [PROD_W-1:0] lo_ext;
    logic signed [PROD_W-1:0] prod;

    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;

    logic signed [ACC_W-1:0]  mix_ext;
    logic signed [ACC_W-1:0]  frame_sum;
    logic signed [ACC_W:0]    sum_ext;
    logic signed [ACC_W:0]    shifted;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [OUT_W-1:0]  dump_val;

    // Stage 1: capture the aligned sample pair.
    always_ff @(posedge clock) begin
        if (resest) begin
            adc_q <= '0;
            lo_q  <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= adc_valid & ~clear;
            if (adc_valid && !clear) begin
                adc_q <= adc_data;
                lo_q  <= lo_sin;
            end
        end
    end

    // The product of two sign-extended operands truncated to PROD_W bits is exact.
    always_comb begin
        adc_ext = {{LO_W{adc_q[DATA_W-1]}}, adc_q};
        lo_ext  = {{DATA_W{lo_q[LO_W-1]}}, lo_q};
        prod    = adc_ext * lo_ext;
    end

    // Stage 2: registered mixer output.
    always_ff @(posedge clock) begin
        if (resest) begin
            mix_o     <= '0;
            mix_valid <= 1'b0;
        end else if (clear) begin
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= v1_q;
            if (v1_q) begin
                mix_o <= prod;
            end
        end
    end

    // Frame sum includes the current product; widened by one bit so the round offset cannot wrap.
    always_comb begin
        mix_ext   = {{(ACC_W - PROD_W){mix_o[PROD_W-1]}}, mix_o};
        frame_sum = acc_q + mix_ext;
        sum_ext   = {frame_sum[ACC_W-1], frame_sum} + RND;
        shifted   = sum_ext >>> SHIFT;
        sat_hi    = shifted > SAT_MAX;
        sat_lo    = shifted < SAT_MIN;
        if (sat_hi) begin
            dump_val = OUT_MAX;
        end else if (sat_lo) begin
            dump_val = OUT_MIN;
        end else begin
            dump_val = shifted[OUT_W-1:0];
        end
    end

    // Stage 3: integrate valid products and dump every DUMP_LEN of them.
    always_ff @(posedge clock) begin
        if (resest) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            acc_o     <= '0;
            acc_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clear) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            acc_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (mix_valid) begin
                if (cnt_q == CNT_LAST) begin
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    acc_o     <= dump_val;
                    acc_valid <= 1'b1;
                    if (sat_hi || sat_lo) begin
                        sat_flag <= 1'b1;
                    end
                end else begin
                    acc_q <= frame_sum;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_costas_mix_int_dump.sv
// Scoreboard bench for costas_mix_int_dump: a (DUMP_LEN=4, SHIFT=0) and b (DUMP_LEN=2, SHIFT=2).
module tb_costas_mix_int_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               a_rst, a_valid, a_clear, a_mix_valid, a_acc_valid, a_sat;
    logic signed [13:0] a_data, a_lo;
    logic signed [27:0] a_mix;
    logic signed [17:0] a_acc;
    logic               b_rst, b_valid, b_clear, b_mix_valid, b_acc_valid, b_sat;
    logic signed [13:0] b_data, b_lo;
    logic signed [27:0] b_mix;
    logic signed [17:0] b_acc;

    costas_mix_int_dump #(.DUMP_LEN(4), .SHIFT(0)) dut_a (
        .clock(clk), .resest(a_rst), .adc_data(a_data), .adc_valid(a_valid), .lo_sin(a_lo),
        .clear(a_clear), .mix_o(a_mix), .mix_valid(a_mix_valid), .acc_o(a_acc),
        .acc_valid(a_acc_valid), .sat_flag(a_sat)
    );

    costas_mix_int_dump #(.DUMP_LEN(2), .SHIFT(2)) dut_b (
        .clock(clk), .resest(b_rst), .adc_data(b_data), .adc_valid(b_valid), .lo_sin(b_lo),
        .clear(b_clear), .mix_o(b_mix), .mix_valid(b_mix_valid), .acc_o(b_acc),
        .acc_valid(b_acc_valid), .sat_flag(b_sat)
    );

    typedef struct {
        longint      val;
        bit          sat;
        int unsigned cyc;
    } dump_t;

    dump_t  q_a[$];
    dump_t  q_b[$];
    dump_t  da, db;
    longint m_acc_a, m_acc_b, m_last_a;
    int     m_cnt_a, m_cnt_b;
    bit     m_sat_a, m_sat_b;
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic dump_t mk_dump(longint sum, int sh, bit sticky, int unsigned c);
        dump_t  d;
        longint r;
        r = sum;
`ifdef COSTAS_DUMP_ROUND_EN
        if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
`endif
        r = r >>> sh;
        d.sat = sticky;
        if (r > 131071) begin
            r = 131071;
            d.sat = 1'b1;
        end else if (r < -131072) begin
            r = -131072;
            d.sat = 1'b1;
        end
        d.val = r;
        d.cyc = c;
        return d;
    endfunction

    // Inputs are sampled on the next edge; a dump is visible three cycles after that cycle.
    task automatic drive_a(bit v, int a, int b, bit clr, bit rst);
        int unsigned c;
        dump_t d;
        c = cyc;
        a_valid = v; a_data = a[13:0]; a_lo = b[13:0]; a_clear = clr; a_rst = rst;
        if (rst || clr) begin
            m_acc_a = 0; m_cnt_a = 0; m_sat_a = 1'b0;
            if (rst) m_last_a = 0;
        end else if (v) begin
            m_acc_a += longint'(a) * longint'(b);
            m_cnt_a++;
            if (m_cnt_a == 4) begin
                d = mk_dump(m_acc_a, 0, m_sat_a, c + 3);
                m_sat_a = d.sat;
                q_a.push_back(d);
                m_acc_a = 0; m_cnt_a = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drive_b(bit v, int a, int b);
        int unsigned c;
        dump_t d;
        c = cyc;
        b_valid = v; b_data = a[13:0]; b_lo = b[13:0];
        if (v) begin
            m_acc_b += longint'(a) * longint'(b);
            m_cnt_b++;
            if (m_cnt_b == 2) begin
                d = mk_dump(m_acc_b, 2, m_sat_b, c + 3);
                m_sat_b = d.sat;
                q_b.push_back(d);
                m_acc_b = 0; m_cnt_b = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain_a();
        drive_a(0, 0, 0, 0, 0);
        for (int i = 0; i < 8 && q_a.size() != 0; i++) drive_a(0, 0, 0, 0, 0);
        n_cmp++;
        if (q_a.size() != 0) begin
            n_bad++;
            $display("FAIL a_dump_timeout: %0d dumps outstanding, required 0", q_a.size());
        end
    endtask

    task automatic drain_b();
        drive_b(0, 0, 0);
        for (int i = 0; i < 8 && q_b.size() != 0; i++) drive_b(0, 0, 0);
        n_cmp++;
        if (q_b.size() != 0) begin
            n_bad++;
            $display("FAIL b_dump_timeout: %0d dumps outstanding, required 0", q_b.size());
        end
    endtask

    always @(negedge clk) begin
        if (a_acc_valid === 1'b1) begin
            n_cmp++;
            if (q_a.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_dump: acc_valid=1 acc_o=%0d at cycle %0d, required none",
                         a_acc, cyc);
            end else begin
                da = q_a.pop_front();
                m_last_a = da.val;
                if (a_acc !== 18'(da.val) || a_sat !== da.sat || cyc != da.cyc) begin
                    n_bad++;
                    $display("FAIL a_dump: acc_o=%0d sat=%0b cycle=%0d, required acc_o=%0d sat=%0b cycle=%0d",
                             a_acc, a_sat, cyc, da.val, da.sat, da.cyc);
                end
            end
        end
        if (b_acc_valid === 1'b1) begin
            n_cmp++;
            if (q_b.size() == 0) begin
                n_bad++;
                $display("FAIL b_unexpected_dump: acc_valid=1 acc_o=%0d at cycle %0d, required none",
                         b_acc, cyc);
            end else begin
                db = q_b.pop_front();
                if (b_acc !== 18'(db.val) || b_sat !== db.sat || cyc != db.cyc) begin
                    n_bad++;
                    $display("FAIL b_dump: acc_o=%0d sat=%0b cycle=%0d, required acc_o=%0d sat=%0b cycle=%0d",
                             b_acc, b_sat, cyc, db.val, db.sat, db.cyc);
                end
            end
        end
    end

    task automatic test_reset();
        b_rst = 1'b1;
        m_acc_b = 0; m_cnt_b = 0; m_sat_b = 1'b0;
        drive_a(0, 0, 0, 0, 1);
        b_rst = 1'b0;
        n_cmp++;
        if ({a_mix_valid, a_acc_valid, a_sat} !== 3'b000 || a_mix !== 28'sd0 || a_acc !== 18'sd0) begin
            n_bad++;
            $display("FAIL reset_a: mix_valid/acc_valid/sat=%b mix_o=%0d acc_o=%0d, required 000 0 0",
                     {a_mix_valid, a_acc_valid, a_sat}, a_mix, a_acc);
        end
        n_cmp++;
        if ({b_mix_valid, b_acc_valid, b_sat} !== 3'b000 || b_mix !== 28'sd0 || b_acc !== 18'sd0) begin
            n_bad++;
            $display("FAIL reset_b: mix_valid/acc_valid/sat=%b mix_o=%0d acc_o=%0d, required 000 0 0",
                     {b_mix_valid, b_acc_valid, b_sat}, b_mix, b_acc);
        end
    endtask

    task automatic test_basic();
        drive_a(1, 100, 200, 0, 0);
        n_cmp++;
        if (a_mix_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_mix_latency: mix_valid=%b one cycle in, required 0", a_mix_valid);
        end
        drive_a(1, 100, 200, 0, 0);
        n_cmp++;
        if (a_mix_valid !== 1'b1 || a_mix !== 28'sd20000) begin
            n_bad++;
            $display("FAIL basic_mix: mix_valid=%b mix_o=%0d, required 1 20000", a_mix_valid, a_mix);
        end
        for (int i = 0; i < 6; i++) drive_a(1, 100, 200, 0, 0);
        drain_a();
        n_cmp++;
        if (a_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_sat: sat_flag=%b, required 0", a_sat);
        end
    endtask

    task automatic test_saturate();
        drive_a(1, -8192, -8192, 0, 0);
        drive_a(1, -8192, -8192, 0, 0);
        n_cmp++;
        if (a_mix !== 28'sd67108864) begin
            n_bad++;
            $display("FAIL sat_mix: mix_o=%0d, required 67108864", a_mix);
        end
        drive_a(1, -8192, -8192, 0, 0);
        drive_a(1, -8192, -8192, 0, 0);
        drain_a();
        for (int i = 0; i < 4; i++) drive_a(1, 1, 1, 0, 0);
        drain_a();
        n_cmp++;
        if (a_sat !== 1'b1 || a_acc !== 18'sd4) begin
            n_bad++;
            $display("FAIL sat_sticky: sat_flag=%b acc_o=%0d, required 1 4", a_sat, a_acc);
        end
        drive_a(0, 0, 0, 1, 0);
        drive_a(0, 0, 0, 0, 0);
        n_cmp++;
        if (a_sat !== 1'b0 || a_acc !== 18'(m_last_a)) begin
            n_bad++;
            $display("FAIL sat_clear: sat_flag=%b acc_o=%0d, required 0 %0d", a_sat, a_acc, m_last_a);
        end
    endtask

    task automatic test_gaps();
        bit [8:0] pat;
        pat = 9'b100100101;
        for (int i = 0; i < 9; i++) drive_a(pat[i], 10, -3, 0, 0);
        drain_a();
        n_cmp++;
        if (a_acc !== -18'sd120) begin
            n_bad++;
            $display("FAIL gaps_acc: acc_o=%0d, required -120", a_acc);
        end
    endtask

    task automatic test_clear();
        drive_a(1, 7, 7, 0, 0);
        drive_a(1, 7, 7, 0, 0);
        drive_a(0, 0, 0, 1, 0);
        n_cmp++;
        if (a_acc_valid !== 1'b0 || a_mix_valid !== 1'b0 || a_acc !== 18'(m_last_a)) begin
            n_bad++;
            $display("FAIL clear_hold: acc_valid=%b mix_valid=%b acc_o=%0d, required 0 0 %0d",
                     a_acc_valid, a_mix_valid, a_acc, m_last_a);
        end
        for (int i = 0; i < 4; i++) drive_a(1, 1, 1, 0, 0);
        drain_a();
        n_cmp++;
        if (a_acc !== 18'sd4) begin
            n_bad++;
            $display("FAIL clear_restart: acc_o=%0d, required 4", a_acc);
        end
        // Clear lands on the edge where the frame-completing product is in stage 3.
        for (int i = 0; i < 3; i++) drive_a(1, 5, 5, 0, 0);
        drive_a(1, 5, 5, 0, 0);
        void'(q_a.pop_back());
        drive_a(0, 0, 0, 0, 0);
        drive_a(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive_a(0, 0, 0, 0, 0);
        n_cmp++;
        if (a_acc !== 18'sd4) begin
            n_bad++;
            $display("FAIL clear_priority: acc_o=%0d, required 4 (no dump)", a_acc);
        end
        for (int i = 0; i < 4; i++) drive_a(1, 2, 2, 0, 0);
        drain_a();
    endtask

    task automatic test_round();
        longint e1, e2;
`ifdef COSTAS_DUMP_ROUND_EN
        e1 = 2; e2 = -1;
`else
        e1 = 1; e2 = -2;
`endif
        drive_b(1, 3, 1);
        drive_b(1, 3, 1);
        drain_b();
        n_cmp++;
        if (b_acc !== 18'(e1)) begin
            n_bad++;
            $display("FAIL round_pos: acc_o=%0d, required %0d", b_acc, e1);
        end
        drive_b(1, -3, 1);
        drive_b(1, -3, 1);
        drain_b();
        n_cmp++;
        if (b_acc !== 18'(e2)) begin
            n_bad++;
            $display("FAIL round_neg: acc_o=%0d, required %0d", b_acc, e2);
        end
    endtask

    task automatic test_reset_mid();
        drive_a(1, 1, 1, 0, 0);
        drive_a(1, 1, 1, 0, 0);
        drive_a(1, 1, 1, 0, 1);
        n_cmp++;
        if ({a_mix_valid, a_acc_valid, a_sat} !== 3'b000 || a_mix !== 28'sd0 || a_acc !== 18'sd0) begin
            n_bad++;
            $display("FAIL reset_mid: mix_valid/acc_valid/sat=%b mix_o=%0d acc_o=%0d, required 000 0 0",
                     {a_mix_valid, a_acc_valid, a_sat}, a_mix, a_acc);
        end
        for (int i = 0; i < 4; i++) drive_a(1, 2, 3, 0, 0);
        drain_a();
        n_cmp++;
        if (a_acc !== 18'sd24) begin
            n_bad++;
            $display("FAIL reset_mid_frame: acc_o=%0d, required 24", a_acc);
        end
    endtask

    initial begin
        a_rst = 1'b0; a_valid = 1'b0; a_clear = 1'b0; a_data = '0; a_lo = '0;
        b_rst = 1'b0; b_valid = 1'b0; b_clear = 1'b0; b_data = '0; b_lo = '0;
        m_acc_a = 0; m_cnt_a = 0; m_sat_a = 1'b0; m_last_a = 0;
        m_acc_b = 0; m_cnt_b = 0; m_sat_b = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_saturate();
        test_gaps();
        test_clear();
        test_round();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
